// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM sample sequencer: FSM state encoding and
// default widths matching the 1-bit music-signal block ROM.
package rom_seq_pkg;

   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_DATA_WIDTH = 1;
   localparam int DEF_DIV_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/rom_seq_hold_counter.sv
// Loadable down-counter that times the HOLD phase of each sample. It parks
// at zero so the FSM can use the zero flag as the end-of-hold condition.
module rom_seq_hold_counter
   import rom_seq_pkg::*;
#(
   parameter int WIDTH = DEF_DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Reload on request, otherwise count down while enabled and stop at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/rom_sample_sequencer.sv
// Walks ROM addresses 0..len at a programmable period, absorbs the ROM's
// one-cycle read latency and holds each fetched bit as the output sample.
// Every sample costs FETCH + LOAD + (div+1) HOLD cycles.
module rom_sample_sequencer
   import rom_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  loop_i,
   input  logic [ADDR_WIDTH-1:0] len_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   output logic [DATA_WIDTH-1:0] sample_o,
   output logic                  sample_valid_o,
   output logic                  busy_o,
   output logic                  done_o
);

   seq_state_t            state;
   logic [ADDR_WIDTH-1:0] len_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic                  loop_q;
   logic                  hold_load;
   logic                  hold_en;
   logic                  hold_zero;

   // The counter is armed as the sample is captured and runs through HOLD;
   // an abort suppresses both so nothing is left half-started.
   assign hold_load = (state == LOAD) && !stop_i;
   assign hold_en   = (state == HOLD) && !stop_i;

   rom_seq_hold_counter #(
      .WIDTH(DIV_WIDTH)
   ) u_hold_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (hold_load),
      .enable    (hold_en),
      .load_value(div_q),
      .zero      (hold_zero)
   );

   // Playback FSM with registered outputs; an abort outranks every other
   // transition and drops straight back to a silent, address-zero IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         len_q          <= '0;
         div_q          <= '0;
         loop_q         <= 1'b0;
         rom_addr_o     <= '0;
         sample_o       <= '0;
         sample_valid_o <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         sample_valid_o <= 1'b0;
         done_o         <= 1'b0;
         if (stop_i && (state != IDLE)) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            sample_o   <= '0;
            rom_addr_o <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i && !stop_i) begin
                     len_q      <= len_i;
                     div_q      <= div_i;
                     loop_q     <= loop_i;
                     rom_addr_o <= '0;
                     busy_o     <= 1'b1;
                     state      <= FETCH;
                  end
               end
               FETCH: begin
                  state <= LOAD;
               end
               LOAD: begin
                  sample_o       <= rom_data_i;
                  sample_valid_o <= 1'b1;
                  state          <= HOLD;
               end
               HOLD: begin
                  if (hold_zero) begin
                     if (rom_addr_o != len_q) begin
                        rom_addr_o <= rom_addr_o + 1'b1;
                        state      <= FETCH;
                     end else if (loop_q) begin
                        rom_addr_o <= '0;
                        state      <= FETCH;
                     end else begin
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        sample_o   <= '0;
                        rom_addr_o <= '0;
                        state      <= IDLE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rom_sample_sequencer.sv
// Scoreboard bench for rom_sample_sequencer: stimulus pushes the expected
// sample/done events, a monitor pops and checks them as the DUT emits them.
module tb_rom_sample_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        stop_i;
   logic        loop_i;
   logic [7:0]  len_i;
   logic [15:0] div_i;
   logic [7:0]  rom_addr_o;
   logic [0:0]  rom_data_i;
   logic [0:0]  sample_o;
   logic        sample_valid_o;
   logic        busy_o;
   logic        done_o;

   typedef struct {
      bit         is_done;
      logic [7:0] addr;
      logic       data;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;
   int   last_cyc = 0;
   bit   busy_prev = 1'b0;

   rom_sample_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .loop_i        (loop_i),
      .len_i         (len_i),
      .div_i         (div_i),
      .rom_addr_o    (rom_addr_o),
      .rom_data_i    (rom_data_i),
      .sample_o      (sample_o),
      .sample_valid_o(sample_valid_o),
      .busy_o        (busy_o),
      .done_o        (done_o)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM contents: 1,0,1,0,0,1,0,1 repeating (bit0 inverted, xor bit2).
   function automatic logic rom_bit(int a);
      return ~a[0] ^ a[2];
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clk) rom_data_i <= rom_bit(int'(rom_addr_o));

   task automatic checkOutput(string name, int actual, int expected);
      total++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   task automatic push_sample(int addr, logic data, int gap);
      exp_t e;
      e.is_done = 1'b0; e.addr = addr[7:0]; e.data = data; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic push_done(int gap);
      exp_t e;
      e.is_done = 1'b1; e.addr = 8'd0; e.data = 1'b0; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Issue a start from a falling edge; returns at the falling edge after
   // the start was sampled.
   task automatic applyStimulus(int len, int div, bit loop);
      start_i = 1'b1;
      len_i   = len[7:0];
      div_i   = div[15:0];
      loop_i  = loop;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic drain(string tag, int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   // Monitor: gaps are measured from the start acceptance (busy rising) or
   // from the previous sample/done event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            busy_prev = 1'b0;
         end else begin
            if (busy_o && !busy_prev) last_cyc = cyc;
            if (sample_valid_o || done_o) begin
               if (exp_q.size() == 0) begin
                  total++;
                  $display("[TB] FAIL unexpected_event: got valid=%0d done=%0d addr=%0d expected none",
                           sample_valid_o, done_o, rom_addr_o);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("event_kind", int'(done_o), int'(e.is_done));
                  checkOutput("event_addr", int'(rom_addr_o), int'(e.addr));
                  checkOutput("event_sample", int'(sample_o), int'(e.data));
                  checkOutput("event_gap", cyc - last_cyc, e.gap);
                  if (e.is_done) checkOutput("done_busy", int'(busy_o), 0);
               end
               last_cyc = cyc;
            end
            busy_prev = busy_o;
         end
      end
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
      len_i = 8'd0; div_i = 16'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset_addr", int'(rom_addr_o), 0);
      checkOutput("reset_sample", int'(sample_o), 0);
      checkOutput("reset_valid", int'(sample_valid_o), 0);
      checkOutput("reset_busy", int'(busy_o), 0);
      checkOutput("reset_done", int'(done_o), 0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] three samples, no loop");
      push_sample(0, 1'b1, 2);
      push_sample(1, 1'b0, 3);
      push_sample(2, 1'b1, 3);
      push_done(1);
      applyStimulus(2, 0, 1'b0);
      checkOutput("start_busy", int'(busy_o), 1);
      drain("drain_three", 40);
      checkOutput("end_sample", int'(sample_o), 0);
      checkOutput("end_busy", int'(busy_o), 0);
      checkOutput("end_addr", int'(rom_addr_o), 0);

      $display("[TB] looping len=1 div=4, then stop in HOLD");
      push_sample(0, 1'b1, 2);
      push_sample(1, 1'b0, 7);
      push_sample(0, 1'b1, 7);
      push_sample(1, 1'b0, 7);
      applyStimulus(1, 4, 1'b1);
      drain("drain_loop", 80);
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      checkOutput("stop_hold_busy", int'(busy_o), 0);
      checkOutput("stop_hold_sample", int'(sample_o), 0);
      checkOutput("stop_hold_addr", int'(rom_addr_o), 0);
      repeat (12) @(negedge clk);
      checkOutput("stop_hold_quiet", exp_q.size(), 0);

      $display("[TB] full ROM with loop wrap");
      for (int a = 0; a < 256; a++) push_sample(a, rom_bit(a), (a == 0) ? 2 : 3);
      push_sample(0, rom_bit(0), 3);
      push_sample(1, rom_bit(1), 3);
      applyStimulus(255, 0, 1'b1);
      drain("drain_wrap", 1000);
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      checkOutput("stop_wrap_busy", int'(busy_o), 0);
      repeat (5) @(negedge clk);

      $display("[TB] start with stop in IDLE");
      start_i = 1'b1; stop_i = 1'b1; len_i = 8'd2; div_i = 16'd0;
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0;
      checkOutput("startstop_busy", int'(busy_o), 0);
      repeat (5) @(negedge clk);

      $display("[TB] start while busy is ignored");
      push_sample(0, 1'b1, 2);
      push_sample(1, 1'b0, 4);
      push_sample(2, 1'b1, 4);
      push_sample(3, 1'b0, 4);
      push_done(2);
      applyStimulus(3, 1, 1'b0);
      repeat (3) @(negedge clk);
      applyStimulus(0, 0, 1'b1);
      drain("drain_ignore", 60);
      checkOutput("ignore_end_busy", int'(busy_o), 0);

      $display("[TB] single sample, then stop in FETCH");
      push_sample(0, 1'b1, 2);
      push_done(1);
      applyStimulus(0, 0, 1'b0);
      drain("drain_single", 20);
      repeat (2) @(negedge clk);
      start_i = 1'b1; len_i = 8'd2; div_i = 16'd0; loop_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      checkOutput("stop_fetch_busy", int'(busy_o), 0);
      repeat (6) @(negedge clk);
      checkOutput("stop_fetch_quiet", exp_q.size(), 0);

      $display("[TB] reset during LOAD");
      applyStimulus(2, 0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_load_busy", int'(busy_o), 0);
      checkOutput("rst_load_addr", int'(rom_addr_o), 0);
      checkOutput("rst_load_sample", int'(sample_o), 0);
      checkOutput("rst_load_valid", int'(sample_valid_o), 0);
      checkOutput("rst_load_done", int'(done_o), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      push_sample(0, 1'b1, 2);
      push_sample(1, 1'b0, 3);
      push_done(1);
      applyStimulus(1, 0, 1'b0);
      drain("drain_after_reset", 30);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
